// File: rtl/sample_serializer.sv
// sample_serializer: requests one sample from the sample generator per frame
// and shifts it out as a left-justified mono frame (left slot, then the same
// word in the right slot) on the DAC pins bclk / lrclk / sdata.
module sample_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 4,   // clk cycles per bclk half-period, >= 2
  parameter int TIMEOUT      = 8    // max WAIT cycles before giving up
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_frame,
  output logic                    generate_next,
  input  logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    busy,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_dropped,
  output logic                    timed_out
);

  localparam int BIT_W  = $clog2(2 * SAMPLE_WIDTH);
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  LEFT_LAST  = BIT_W'(SAMPLE_WIDTH - 1);
  localparam logic [BIT_W-1:0]  RIGHT_LAST = BIT_W'(2 * SAMPLE_WIDTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT,
    SHIFT
  } state_t;

  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] held_word;  // word replayed for the right slot
  logic [SAMPLE_WIDTH-1:0] shreg;      // MSB is the bit currently on sdata
  logic [BIT_W-1:0]        bit_cnt;    // 0..2*SAMPLE_WIDTH-1 across both slots
  logic [DIV_W-1:0]        div_cnt;
  logic [TCNT_W-1:0]       tcnt;
  logic [TCNT_W-1:0]       tcnt_next;

  assign tcnt_next = tcnt + TCNT_W'(1);

  // Handshake FSM, bclk divider and serial shifter; all outputs registered.
  // NOTE: every register here is written with <= so all updates in a cycle
  // see the pre-edge values; a blocking = would let later statements see
  // half-updated state and break the shift/divider ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      generate_next <= 1'b0;
      busy          <= 1'b0;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      frame_dropped <= 1'b0;
      timed_out     <= 1'b0;
      held_word     <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      tcnt          <= '0;
    end else begin
      // A request arriving while a frame is in flight is discarded.
      if (new_frame && state != IDLE) frame_dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (new_frame) begin
            state         <= REQUEST;
            generate_next <= 1'b1;
            busy          <= 1'b1;
          end
        end

        REQUEST: begin
          generate_next <= 1'b0;
          tcnt          <= '0;
          state         <= WAIT;
        end

        WAIT: begin
          tcnt <= tcnt_next;
          if (sample_ready) begin
            held_word <= sample;
            shreg     <= sample;
            sdata     <= sample[SAMPLE_WIDTH-1];
            bit_cnt   <= '0;
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            state     <= SHIFT;
          end else if (tcnt_next == TCNT_LAST) begin
            // Generator never answered: send silence and flag it.
            held_word <= '0;
            shreg     <= '0;
            sdata     <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            timed_out <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            // Data only moves on the falling bclk edge (bclk currently high).
            if (bclk) begin
              if (bit_cnt == RIGHT_LAST) begin
                state   <= IDLE;
                busy    <= 1'b0;
                bclk    <= 1'b0;
                lrclk   <= 1'b0;
                sdata   <= 1'b0;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                if (bit_cnt == LEFT_LAST) begin
                  lrclk <= 1'b1;
                  shreg <= held_word;
                  sdata <= held_word[SAMPLE_WIDTH-1];
                end else begin
                  shreg <= {shreg[SAMPLE_WIDTH-2:0], 1'b0};
                  sdata <= shreg[SAMPLE_WIDTH-2];
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Self-checking bench for sample_serializer. The expected serial frame is
// built from the word alone (left slot then right slot, MSB first); timing
// expectations come from the frame arithmetic (half-period, slot length).
module tb_sample_serializer;

  localparam int W         = 16;
  localparam int DIV       = 4;
  localparam int TO        = 8;
  localparam int FRAME_LEN = 2 * W * 2 * DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         new_frame = 1'b0;
  logic         generate_next;
  logic         sample_ready = 1'b0;
  logic [W-1:0] sample = '0;
  logic         busy, bclk, lrclk, sdata, frame_dropped, timed_out;

  int   errors = 0;
  int   checks = 0;
  logic exp_timed_out = 1'b0;
  logic exp_dropped   = 1'b0;

  sample_serializer #(
    .SAMPLE_WIDTH(W),
    .BCLK_DIV    (DIV),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .generate_next(generate_next),
    .sample_ready (sample_ready),
    .sample       (sample),
    .busy         (busy),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_dropped(frame_dropped),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame transaction.
  //   delay    : WAIT cycle (1..TO) in which sample_ready is given; 0 = never
  //   early    : also pulse sample_ready with early_word in the REQUEST cycle
  //   drop_at  : SHIFT cycle index in which a stray new_frame is driven (-1 none)
  //   reset_at : SHIFT cycle index in which reset is asserted (-1 none)
  task automatic run_frame(input string name, input logic [W-1:0] word,
                           input int delay, input bit early,
                           input logic [W-1:0] early_word,
                           input int drop_at, input int reset_at);
    logic [W-1:0] exp_word;
    logic [1:0]   got_q[$];
    logic [1:0]   exp_bit;
    int           gen_cnt;
    int           cnt;
    int           first_rise;
    int           lr_rise;
    logic         prev_bclk;
    logic         prev_lr;
    bit           aborted;

    gen_cnt = 0; first_rise = -1; lr_rise = -1; aborted = 0;

    // IDLE cycle: request a frame.
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    checks++;
    if (generate_next !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s request: got gen=%b busy=%b want gen=1 busy=1", name, generate_next, busy);
    end
    if (generate_next === 1'b1) gen_cnt++;

    // REQUEST cycle: an early sample_ready here must be ignored.
    if (early) begin
      sample_ready = 1'b1;
      sample       = early_word;
    end
    tick();
    sample_ready = 1'b0;
    checks++;
    if (generate_next !== 1'b0) begin
      errors++;
      $display("FAIL %s gen_width: got gen=%b in WAIT want 0", name, generate_next);
    end

    // WAIT cycle 1 now.
    if (delay > 0) begin
      repeat (delay - 1) begin
        sample = W'($urandom);
        tick();
      end
      sample_ready = 1'b1;
      sample       = word;
      tick();
      sample_ready = 1'b0;
      exp_word     = word;
    end else begin
      repeat (TO - 1) tick();
      checks++;
      if (timed_out !== exp_timed_out || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s pre_timeout: got timed_out=%b busy=%b want %b 1", name, timed_out, busy, exp_timed_out);
      end
      tick();
      exp_timed_out = 1'b1;
      exp_word      = '0;
    end

    // SHIFT entry: MSB already on sdata, bclk and lrclk low.
    checks++;
    if (busy !== 1'b1 || bclk !== 1'b0 || lrclk !== 1'b0 || sdata !== exp_word[W-1]) begin
      errors++;
      $display("FAIL %s shift_entry: got busy=%b bclk=%b lrclk=%b sdata=%b want 1 0 0 %b",
               name, busy, bclk, lrclk, sdata, exp_word[W-1]);
    end
    checks++;
    if (timed_out !== exp_timed_out) begin
      errors++;
      $display("FAIL %s timed_out: got %b want %b", name, timed_out, exp_timed_out);
    end

    cnt = 0;
    prev_bclk = bclk;
    prev_lr   = lrclk;
    while (cnt < FRAME_LEN + 64) begin
      if (cnt == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample_ready  = 1'b0;
        exp_timed_out = 1'b0;
        exp_dropped   = 1'b0;
        checks++;
        if ({generate_next, busy, bclk, lrclk, sdata, frame_dropped, timed_out} !== 7'b0) begin
          errors++;
          $display("FAIL %s mid_reset: got gen,busy,bclk,lr,sd,drop,to=%b want 0000000", name,
                   {generate_next, busy, bclk, lrclk, sdata, frame_dropped, timed_out});
        end
        aborted = 1;
        break;
      end
      new_frame    = (cnt == drop_at);
      sample_ready = 1'($urandom_range(0, 1));  // must be ignored in SHIFT
      sample       = W'($urandom);
      tick();
      new_frame = 1'b0;
      cnt++;
      if (generate_next === 1'b1) gen_cnt++;
      if (drop_at >= 0 && cnt == drop_at + 1) begin
        exp_dropped = 1'b1;
        checks++;
        if (frame_dropped !== 1'b1) begin
          errors++;
          $display("FAIL %s drop_flag: got %b want 1", name, frame_dropped);
        end
      end
      if (!prev_bclk && bclk === 1'b1) begin
        got_q.push_back({lrclk, sdata});
        if (first_rise < 0) first_rise = cnt;
      end
      if (!prev_lr && lrclk === 1'b1 && lr_rise < 0) lr_rise = cnt;
      prev_bclk = bclk;
      prev_lr   = lrclk;
      if (busy !== 1'b1) break;
    end
    sample_ready = 1'b0;

    if (!aborted) begin
      checks++;
      if (cnt != FRAME_LEN) begin
        errors++;
        $display("FAIL %s frame_len: got %0d want %0d", name, cnt, FRAME_LEN);
      end
      checks++;
      if (bclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0) begin
        errors++;
        $display("FAIL %s frame_end_pins: got bclk=%b lrclk=%b sdata=%b want 0 0 0", name, bclk, lrclk, sdata);
      end
      checks++;
      if (first_rise != DIV) begin
        errors++;
        $display("FAIL %s first_bclk_rise: got %0d want %0d", name, first_rise, DIV);
      end
      checks++;
      if (lr_rise != 2 * DIV * W) begin
        errors++;
        $display("FAIL %s lrclk_rise: got %0d want %0d", name, lr_rise, 2 * DIV * W);
      end
      checks++;
      if (got_q.size() != 2 * W) begin
        errors++;
        $display("FAIL %s bit_count: got %0d want %0d", name, got_q.size(), 2 * W);
      end else begin
        for (int k = 0; k < 2 * W; k++) begin
          exp_bit = {1'(k >= W), exp_word[W-1-(k % W)]};
          checks++;
          if (got_q[k] !== exp_bit) begin
            errors++;
            $display("FAIL %s bit%0d: got lr,sd=%b want %b (word %h)", name, k, got_q[k], exp_bit, exp_word);
          end
        end
      end
      checks++;
      if (gen_cnt != 1) begin
        errors++;
        $display("FAIL %s gen_pulses: got %0d want 1", name, gen_cnt);
      end
      checks++;
      if (frame_dropped !== exp_dropped || timed_out !== exp_timed_out) begin
        errors++;
        $display("FAIL %s flags_end: got drop=%b to=%b want %b %b", name, frame_dropped, timed_out, exp_dropped, exp_timed_out);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({generate_next, busy, bclk, lrclk, sdata, frame_dropped, timed_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {generate_next, busy, bclk, lrclk, sdata, frame_dropped, timed_out});
    end
    // Idle with stray sample_ready: nothing may start.
    sample_ready = 1'b1;
    sample       = 16'hFFFF;
    repeat (3) tick();
    sample_ready = 1'b0;
    checks++;
    if ({generate_next, busy, bclk, lrclk, sdata} !== 5'b0) begin
      errors++;
      $display("FAIL idle_hold: got %b want 00000", {generate_next, busy, bclk, lrclk, sdata});
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 16'hA5C3, 2, 0, '0, -1, -1);
  endtask

  task automatic test_back_to_back();
    // Starts on the first IDLE cycle after the previous frame.
    run_frame("back_to_back", 16'h3C5A, 1, 0, '0, -1, -1);
  endtask

  task automatic test_late_ready();
    // Ready on the final allowed WAIT cycle is still accepted.
    run_frame("late_ready", 16'h9E37, TO, 0, '0, -1, -1);
  endtask

  task automatic test_early_ready();
    tick();
    run_frame("early_ready", 16'h2222, 3, 1, 16'h1111, -1, -1);
  endtask

  task automatic test_drop();
    tick();
    run_frame("drop", 16'h6B1D, 2, 0, '0, 10, -1);
  endtask

  task automatic test_timeout();
    tick();
    run_frame("timeout", 16'h0000, 0, 0, '0, -1, -1);
    run_frame("after_timeout", 16'h8001, 2, 0, '0, -1, -1);
  endtask

  task automatic test_mid_reset();
    tick();
    // Right-channel bit 5 spans SHIFT cycles 168..175.
    run_frame("mid_reset", 16'hC0DE, 2, 0, '0, -1, 172);
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || generate_next !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b gen=%b want 0 0", busy, generate_next);
    end
    run_frame("after_reset", 16'h7FFF, 2, 0, '0, -1, -1);
  endtask

  task automatic test_end_drop();
    tick();
    // new_frame in the last SHIFT cycle is dropped, not started.
    run_frame("end_drop", 16'h5A5A, 4, 0, '0, FRAME_LEN - 1, -1);
    repeat (3) tick();
    checks++;
    if (generate_next !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL end_drop_idle: got gen=%b busy=%b want 0 0", generate_next, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_frame($sformatf("random%0d", n), W'($urandom), $urandom_range(1, TO), 1'($urandom_range(0, 1)),
                W'($urandom), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_late_ready();
    test_early_ready();
    test_drop();
    test_timeout();
    test_mid_reset();
    test_end_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
- Consumer end of the sample-generator handshake. Waits for a frame request, pulses generate_next, and captures the 16-bit sample on sample_ready.
- Shifts the captured sample out as a left-justified serial audio frame on the DAC pins: bclk, lrclk, sdata. Mono: the same sample goes to the left and right slots.
- Sits between the sine/note sample generator and the board's audio DAC.

Parameters:
- SAMPLE_WIDTH, 16: bits per sample and per channel slot.
- BCLK_DIV, 4: clk cycles per bclk half-period; must be ≥2.
- TIMEOUT, 8: max clk cycles to wait for sample_ready after generate_next.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_frame  input  1  one-cycle strobe requesting the next output frame
- generate_next  output  1  one-cycle strobe to the sample generator
- sample_ready  input  1  one-cycle strobe; sample is valid in this cycle
- sample  input  SAMPLE_WIDTH  two's-complement sample from the generator
- busy  output  1  high in every state except IDLE
- bclk  output  1  serial bit clock
- lrclk  output  1  channel select: 0 = left, 1 = right
- sdata  output  1  serial data, MSB first
- frame_dropped  output  1  sticky; set when new_frame arrives while busy
- timed_out  output  1  sticky; set when a sample request times out

Behaviour:
- Reset (synchronous, takes effect at the next clk edge, even mid-frame):
  - State is IDLE.
  - generate_next, busy, bclk, lrclk, sdata, frame_dropped and timed_out are all 0.
  - Shift register, bit counter, divider and timeout counter are cleared.
- IDLE:
  - On new_frame=1, go to REQUEST.
  - Otherwise hold; bclk, lrclk and sdata stay 0.
- REQUEST (exactly 1 cycle):
  - generate_next=1, busy=1; clear the timeout counter; go to WAIT.
- WAIT:
  - Counts clk cycles from 1.
  - If sample_ready=1 on count ≤ TIMEOUT: latch sample into the shift register, go to SHIFT.
  - If count reaches TIMEOUT with no sample_ready: latch 0, set timed_out, go to SHIFT.
  - A sample_ready in the REQUEST cycle itself is ignored (the generator's minimum latency is 1 cycle).
- SHIFT:
  - Divider counts 0..BCLK_DIV-1; bclk toggles when the divider wraps.
  - First bclk half-period is low. sdata presents the MSB on entry to SHIFT, and each later bit changes on the cycle bclk falls. The DAC samples on the rising edge.
  - Bits 0..SAMPLE_WIDTH-1 go out with lrclk=0 (left). lrclk rises on the bclk fall after the left LSB.
  - The same latched word is reloaded and sent again with lrclk=1 (right).
  - After the right LSB's high half-period completes, return to IDLE with bclk=0, lrclk=0, sdata=0.
  - Frame length: 2·SAMPLE_WIDTH·2·BCLK_DIV clk cycles (256 at defaults).
- frame_dropped:
  - Set if new_frame=1 in any non-IDLE state. The request is discarded, never queued.
  - new_frame in the same cycle that SHIFT returns to IDLE counts as dropped.
- Sticky flags clear only on reset.
- sample_ready outside WAIT is ignored; the shift register is unaffected.
- Widths: no arithmetic on sample data; bits are shifted unmodified. Counters are sized for 2·SAMPLE_WIDTH bits, BCLK_DIV and TIMEOUT.

Test Plan:
- Basic frame: reset, new_frame pulse; generator returns sample_ready 2 cycles after generate_next with sample=16'hA5C3 → generate_next high exactly 1 cycle; sdata carries A5C3 MSB-first on 16 bclk rises with lrclk=0, then A5C3 with lrclk=1; busy low 256 cycles after entering SHIFT.
- Timeout: new_frame, sample_ready never asserted → after 8 WAIT cycles timed_out=1 and the frame shifts 32 zero bits; the next frame with sample=16'h8001 serializes correctly and timed_out stays 1.
- Drop: new_frame again 10 cycles into SHIFT → frame_dropped=1, no second generate_next, the current frame completes unchanged.
- Early ready: sample_ready=1 in the REQUEST cycle with sample=16'h1111, then sample_ready with 16'h2222 in WAIT cycle 3 → serialized word is 2222.
- Mid-frame reset: assert reset during right-channel bit 5 → next cycle all outputs 0, state IDLE; a following new_frame with sample=16'h7FFF produces a clean full frame.
- Back-to-back: new_frame on the first IDLE cycle after a frame → accepted, no drop, generate_next 1 cycle later.
